// File: rtl/seq_restoring_divider_if.sv
// Operand and result handshakes of the sequential divider.
// master = requester side, slave = divider side.
interface seq_restoring_divider_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Restoring divider, one (N+1)-bit subtract step per cycle.
// Define DIVIDER_SIGNED_EN for two's-complement truncating division.
module seq_restoring_divider #(
  parameter int N = 32
) (
  input logic                  clk,
  input logic                  rst,
  seq_restoring_divider_if.slave io
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ov_q, ov_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic          accept;
  logic          dvs_zero;
  logic          carry;
  logic [N:0]    t;
  logic [N:0]    d;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  quo_fix;
  logic [N-1:0]  rem_fix;
  logic          unused_r_top;

  assign accept   = io.in_valid & (state_q == IDLE);
  assign dvs_zero = (io.divisor == '0);

  // T - {0,divisor} as T + ~{0,divisor} + 1; carry-out means no borrow
  assign t = {r_q[N-1:0], q_q[N-1]};
  assign {carry, d} = {1'b0, t}
                    + {1'b0, ~{1'b0, dvs_q}}
                    + (N+2)'(1);

  assign q_fin = {q_q[N-2:0], carry};
  assign r_fin = carry ? d[N-1:0] : t[N-1:0];

  // R stays below the divisor, so its top bit never feeds T
  assign unused_r_top = r_q[N];

`ifdef DIVIDER_SIGNED_EN
  logic nq_q, nq_d;
  logic nr_q, nr_d;

  assign a_mag = io.dividend[N-1] ? -io.dividend : io.dividend;
  assign b_mag = io.divisor[N-1]  ? -io.divisor  : io.divisor;

  // MIN/-1 falls out naturally: |MIN| wraps to MIN and negates to MIN
  assign quo_fix = nq_q ? -q_fin : q_fin;
  assign rem_fix = nr_q ? -r_fin : r_fin;

  always_comb begin
    nq_d = nq_q;
    nr_d = nr_q;
    if (accept && !dvs_zero) begin
      nq_d = io.dividend[N-1] ^ io.divisor[N-1];
      nr_d = io.dividend[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nq_q <= 1'b0;
      nr_q <= 1'b0;
    end else begin
      nq_q <= nq_d;
      nr_q <= nr_d;
    end
  end
`else
  assign a_mag   = io.dividend;
  assign b_mag   = io.divisor;
  assign quo_fix = q_fin;
  assign rem_fix = r_fin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = dvs_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ov_q && io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready    = (state_q == IDLE);
    io.out_valid   = ov_q;
    io.quotient    = ov_q ? quo_q : '0;
    io.remainder   = ov_q ? rem_q : '0;
    io.div_by_zero = ov_q & dbz_q;
  end

  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    // out_valid trails entry into DONE by one cycle
    ov_d  = (state_q == DONE) && !(ov_q && io.out_ready);

    if (accept) begin
      if (dvs_zero) begin
        quo_d = '1;
        rem_d = io.dividend;
        dbz_d = 1'b1;
      end else begin
        r_d   = '0;
        q_d   = a_mag;
        dvs_d = b_mag;
        cnt_d = CW'(N-1);
        dbz_d = 1'b0;
      end
    end

    if (state_q == BUSY) begin
      r_d   = carry ? d : t;
      q_d   = q_fin;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        quo_d = quo_fix;
        rem_d = rem_fix;
        dbz_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q  <= 1'b0;
      r_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      ov_q  <= ov_d;
      r_q   <= r_d;
      q_q   <= q_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Multi-cycle unsigned integer divider for the arithmetic/DSP library. It uses a single (N+1)-bit subtract-with-borrow step per cycle under control of a small FSM.
- Accepts one dividend/divisor pair through a valid/ready handshake.
- Returns quotient and remainder through a second valid/ready handshake.
- Intended as the area-cheap alternative to a combinational array divider in datapaths that tolerate N-cycle latency.

Parameters:
N, 32, operand/result width in bits (N >= 2)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  divider can accept operands
dividend  input  N  dividend
divisor  input  N  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  N  quotient
remainder  output  N  remainder
div_by_zero  output  1  result came from divisor == 0; valid only with out_valid

Behaviour:
- One clock; reset is synchronous and active-high. Clock port clk, reset port rst.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0. Internal counter and registers are cleared.
- in_ready = (state==IDLE). It is registered or derived from state only, never from in_valid.
- IDLE, accept = in_valid & in_ready:
  - divisor != 0: capture operands, set R=0 ((N+1)-bit partial remainder), Q=dividend, cnt=N-1, go BUSY.
  - divisor == 0: set quotient={N{1}}, remainder=dividend, div_by_zero=1, go DONE. out_valid asserts the next cycle; BUSY is skipped.
- BUSY, one step per cycle:
  - T = {R[N-1:0], Q[N-1]}.
  - D = T - {1'b0, divisor}, computed as T + ~{0,divisor} + 1 with carry-out.
  - Carry-out 1 (no borrow): R=D, Q={Q[N-2:0],1}.
  - Carry-out 0 (borrow): R=T (restore), Q={Q[N-2:0],0}.
  - cnt decrements each step. On the step with cnt==0, go DONE.
- DONE:
  - out_valid=1. quotient=Q, remainder=R[N-1:0], div_by_zero=0 (except on the zero-divisor path above).
  - Outputs hold stable while out_valid & ~out_ready.
  - out_valid & out_ready -> IDLE the next cycle, out_valid=0.
- Latency, normal path: accept at edge k, out_valid high from edge k+N+1. Zero-divisor path: from edge k+1.
- Throughput: one division per N+2 cycles minimum. No accept while BUSY or DONE; in_valid is ignored there and operands need not be held after accept.
- Widths:
  - R is N+1 bits so T never overflows.
  - remainder < divisor always holds for nonzero divisor.
  - dividend < divisor gives quotient=0, remainder=dividend.
- Reset mid-operation: any state returns to IDLE on the next edge. Outputs return to reset values and the in-flight result is discarded.
- out_ready high while not in DONE has no effect.

Optional Feature:
Macro DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - Magnitudes are divided unsigned.
  - quotient is negated when the signs differ. remainder takes the sign of the dividend (truncating division).
  - Sign fix-up happens on entry to DONE; latency is unchanged.
  - Overflow case MIN/-1: quotient=MIN, remainder=0, div_by_zero=0.
  - Zero divisor: quotient={N{1}} (-1), remainder=dividend.
- Undefined: the logic is purely unsigned as above and no sign logic is synthesized.

Test Plan:
- N=8, 100/7 with out_ready=1 -> out_valid exactly 9 cycles after accept; quotient=14, remainder=2, div_by_zero=0; in_ready low throughout.
- N=8, 255/1, then 3/10 back-to-back with in_valid held high -> 255 r0, then 0 r3; second accept only after in_ready returns in IDLE.
- N=8, 5/0 -> out_valid 1 cycle after accept; quotient=0xFF, remainder=5, div_by_zero=1.
- N=8, 200/13 with out_ready low for 5 cycles in DONE -> quotient=15, remainder=5 held stable; in_ready=0 until handshake completes.
- N=8, assert rst 4 cycles into BUSY of 77/3 -> next cycle IDLE with all outputs 0; a following 77/3 yields 25 r2.
- DIVIDER_SIGNED_EN, N=8: -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF); -128/-1 -> quotient=0x80, remainder=0.
